// File: rtl/wbq_pkg.sv
// Shared types and defaults for the register-file write-back queue.
package wbq_pkg;
  localparam int WBQ_AW = 5;
  localparam int WBQ_DW = 32;

  localparam logic [WBQ_AW-1:0] WBQ_ZERO_RD = 5'd0;

  typedef struct packed {
    logic [WBQ_AW-1:0] rd;
    logic [WBQ_DW-1:0] data;
  } wbq_entry_t;
endpackage

// File: rtl/wbq_match.sv
// Youngest-match search over the queue entries, walking from the head (oldest) to the tail.
// The data path exists only when WBQ_BYPASS_EN is defined.
module wbq_match
  import wbq_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int AW    = WBQ_AW,
  parameter  int DW    = WBQ_DW,
  localparam int CW    = $clog2(DEPTH+1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][AW-1:0] i_rd_arr,
`ifdef WBQ_BYPASS_EN
  input  logic [DEPTH-1:0][DW-1:0] i_data_arr,
  output logic [DW-1:0]            o_data,
`endif
  input  logic [PW-1:0]            i_rd_ptr,
  input  logic [CW-1:0]            i_count,
  input  logic [AW-1:0]            i_addr,
  output logic                     o_hit
);
  logic [PW-1:0] w_idx;

  // Later (younger) matches overwrite earlier ones.
  always_comb begin
    o_hit = 1'b0;
    w_idx = '0;
`ifdef WBQ_BYPASS_EN
    o_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = i_rd_ptr + PW'(i);
      if ((CW'(i) < i_count) && (i_addr != AW'(WBQ_ZERO_RD)) &&
          (i_rd_arr[w_idx] == i_addr)) begin
        o_hit = 1'b1;
`ifdef WBQ_BYPASS_EN
        o_data = i_data_arr[w_idx];
`endif
      end
    end
  end
endmodule

// File: rtl/wb_write_queue.sv
// Two-producer write-back queue draining one entry per cycle into the register file.
// Define WBQ_BYPASS_EN to drive fwdA/fwdB with the youngest pending data (otherwise tied to 0).
module wb_write_queue
  import wbq_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int AW    = WBQ_AW,
  parameter  int DW    = WBQ_DW,
  localparam int CW    = $clog2(DEPTH+1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          in0_valid,
  output logic          in0_ready,
  input  logic [AW-1:0] in0_rd,
  input  logic [DW-1:0] in0_data,
  input  logic          in1_valid,
  output logic          in1_ready,
  input  logic [AW-1:0] in1_rd,
  input  logic [DW-1:0] in1_data,
  input  logic          hold,
  output logic          RegWr,
  output logic [AW-1:0] rw,
  output logic [DW-1:0] busW,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  output logic          hitA,
  output logic          hitB,
  output logic [DW-1:0] fwdA,
  output logic [DW-1:0] fwdB,
  output logic [CW-1:0] count
);
  logic [PW-1:0]            r_wrp, r_rdp;
  logic [CW-1:0]            r_count;
  logic [DEPTH-1:0][AW-1:0] r_rd;
  logic [DEPTH-1:0][DW-1:0] r_data;

  logic          w_st0, w_st1, w_pop;
  logic [PW-1:0] w_wr1_idx;

  // Ready looks only at current occupancy, never at this cycle's pop.
  assign in0_ready = (r_count <  CW'(DEPTH));
  assign in1_ready = (r_count <= CW'(DEPTH-2));

  // rd==0 completes the handshake but is dropped.
  assign w_st0 = in0_valid && in0_ready && (in0_rd != AW'(WBQ_ZERO_RD));
  assign w_st1 = in1_valid && in1_ready && (in1_rd != AW'(WBQ_ZERO_RD));
  assign w_pop = (r_count != '0) && !hold;

  assign w_wr1_idx = w_st0 ? (r_wrp + PW'(1)) : r_wrp;

  always_ff @(posedge CLK) begin
    if (w_st0) begin
      r_rd[r_wrp]   <= in0_rd;
      r_data[r_wrp] <= in0_data;
    end
    if (w_st1) begin
      r_rd[w_wr1_idx]   <= in1_rd;
      r_data[w_wr1_idx] <= in1_data;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_wrp   <= '0;
      r_rdp   <= '0;
      r_count <= '0;
    end else begin
      r_wrp   <= r_wrp + PW'(w_st0) + PW'(w_st1);
      r_rdp   <= r_rdp + PW'(w_pop);
      r_count <= r_count + CW'(w_st0) + CW'(w_st1) - CW'(w_pop);
    end
  end

  assign RegWr = w_pop;
  assign rw    = w_pop ? r_rd[r_rdp]   : '0;
  assign busW  = w_pop ? r_data[r_rdp] : '0;
  assign count = r_count;

`ifdef WBQ_BYPASS_EN
  wbq_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match_a (
    .i_rd_arr(r_rd), .i_data_arr(r_data), .o_data(fwdA),
    .i_rd_ptr(r_rdp), .i_count(r_count), .i_addr(ra), .o_hit(hitA)
  );
  wbq_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match_b (
    .i_rd_arr(r_rd), .i_data_arr(r_data), .o_data(fwdB),
    .i_rd_ptr(r_rdp), .i_count(r_count), .i_addr(rb), .o_hit(hitB)
  );
`else
  wbq_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match_a (
    .i_rd_arr(r_rd), .i_rd_ptr(r_rdp), .i_count(r_count), .i_addr(ra), .o_hit(hitA)
  );
  wbq_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match_b (
    .i_rd_arr(r_rd), .i_rd_ptr(r_rdp), .i_count(r_count), .i_addr(rb), .o_hit(hitB)
  );
  assign fwdA = '0;
  assign fwdB = '0;
`endif
endmodule

// File: doc/wb_write_queue.md
# wb_write_queue

Write-back queue for the register file. Two producers (ALU result and load data) may both finish in the same cycle. The queue buffers their results in order and drains one entry per cycle into the register file's single write port (RegWr/rw/busW). It also exposes two lookup ports so decode can detect, and optionally forward, register values that are still pending.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2
- AW, 5, register address width
- DW, 32, data width
- CLK  in  1  clock; all state changes on the rising edge
- RSTn  in  1  asynchronous, active-low reset
- in0_valid  in  1  ALU result valid
- in0_ready  out  1  queue can accept port 0
- in0_rd  in  AW  port 0 destination register
- in0_data  in  DW  port 0 data
- in1_valid  in  1  load result valid
- in1_ready  out  1  queue can accept port 1
- in1_rd  in  AW  port 1 destination register
- in1_data  in  DW  port 1 data
- hold  in  1  freeze draining (debug or external stall)
- RegWr  out  1  register-file write enable
- rw  out  AW  register-file write address
- busW  out  DW  register-file write data
- ra, rb  in  AW  lookup addresses (rs, rt)
- hitA, hitB  out  1  a pending write targets ra / rb
- fwdA, fwdB  out  DW  data of the youngest pending write to ra / rb
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Circular buffer holds {rd, data} entries, with wr_ptr/rd_ptr (log2(DEPTH) bits, natural wrap) and count.
- **Accept rule:** a port transfers when valid && ready.
- **Ready rules:**
  - in0_ready = count < DEPTH.
  - in1_ready = count <= DEPTH-2.
  - A pop in the same cycle is not credited to ready (conservative), so there is no valid-to-ready combinational path.
- **Same-cycle order:** when both ports transfer, port 0 is written first (older) and port 1 second.
- **rd == 0:** the transfer is accepted but not stored. It still consumes the handshake, and count does not change for it.
- **Drain:** when count != 0 and hold == 0:
  - RegWr = 1, rw = head.rd, busW = head.data, driven combinationally from the head entry.
  - Head pops at the rising edge.
  - Otherwise RegWr = 0, rw = 0, busW = 0.
- **Push and pop together:** count += pushes − pop. Count never exceeds DEPTH and never goes below 0.
- **Lookup:**
  - hitA = 1 when any valid entry has rd == ra and ra != 0.
  - fwdA = data of the youngest matching entry, where age is position from rd_ptr.
  - The head entry being written this cycle still counts as a hit.
  - Same rules for B with rb.
- **Reset (asynchronous, any time):**
  - Pointers and count go to 0; pending entries are discarded.
  - RegWr = 0, rw = 0, busW = 0, hitA/B = 0, fwdA/B = 0.
  - in0_ready = 1, in1_ready = 1.

## Timing
- Enqueue at edge N; with an empty queue and hold = 0, RegWr is high during cycle N+1 and the register file commits at edge N+1.
- Throughput: one drain per cycle; up to two enqueues per cycle.
- Lookup outputs are combinational from ra/rb and queue state. Entries enqueued at edge N are visible in the cycle after edge N.
- hold asserted: RegWr = 0 that cycle and the head is kept. Enqueues continue until ready drops.

## Configuration
- WBQ_BYPASS_EN
  - **Defined:** fwdA/fwdB carry the youngest matching data, so decode can forward instead of stalling.
  - **Undefined:** fwdA/fwdB are tied to 0 and the matching logic carries no data path. hitA/hitB remain and act as stall requests.

## Structure
- Package wbq_pkg holds:
  - AW/DW defaults
  - typedef wbq_entry_t {rd, data}
  - constant for the zero register address (5'd0)
- Sub-module wbq_match: youngest-match search over the entry array, given rd_ptr and count. Instantiated once for A and once for B. Its data output exists only under WBQ_BYPASS_EN.

## Test plan
- **Single write:** reset, then in0 {rd=8, data=0x1234} -> next cycle RegWr=1, rw=8, busW=0x1234; following cycle RegWr=0, count=0.
- **Dual same-cycle order:** in0 {9, 0xA}, in1 {10, 0xB} in one cycle -> drain order rw=9 then rw=10 on consecutive cycles.
- **Full and hold:** with DEPTH=4 and hold=1, dual pushes for 2 cycles -> count=4, in0_ready=0, in1_ready=0; release hold -> four consecutive writes, ready recovers.
- **Zero register:** push {rd=0, 0xFF} -> accepted, count stays 0, RegWr never asserted; ra=0 never hits.
- **Youngest forward:** pending {16, 1} then {16, 2}, ra=16 -> hitA=1; fwdA=2 with WBQ_BYPASS_EN, fwdA=0 without.
- **Reset mid-drain:** 3 entries pending, RSTn low -> RegWr=0, count=0, ready=1 immediately, with no edge required.
